hssim_sel_stream: RTL and testbench
===================================

HSSIM_SEL_STREAM -- requirements
Module: hssim_sel_stream

Interface
REQ-001 SHALL have parameter PIXELS_PER_BEAT, default 16, meaning pixel lanes per beat.
REQ-002 SHALL have parameter PIX_W, default 8, meaning mean/pixel width in bits.
REQ-003 SHALL have parameter IMAGE_DIM, default 512, meaning square frame side in pixels; IMAGE_DIM*IMAGE_DIM SHALL be a multiple of PIXELS_PER_BEAT.
REQ-004 SHALL have parameters C1, default 6, and C2, default 58, meaning the SSIM stabilising constants.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 aresetn  input  1  reset, asynchronous assert, active-low.
REQ-007 s_valid  input  1 / s_ready  output  1  input beat handshake.
REQ-008 mu_x, mu_y, mu_z  input  PIX_W*PIXELS_PER_BEAT each  per-lane means (old, average, new map).
REQ-009 sig_xx, sig_yy, sig_zz, sig_xy, sig_zy  input  2*PIX_W*PIXELS_PER_BEAT each  per-lane unsigned (co)variances.
REQ-010 cfg_ge  input  1  compare mode, sampled with each accepted beat: 0 strict (p2>p1), 1 inclusive (p2>=p1).
REQ-011 frame_clr  input  1  synchronous clear of frame position and statistics.
REQ-012 m_valid  output  1 / m_ready  input  1  output beat handshake.
REQ-013 m_data  output  PIX_W*PIXELS_PER_BEAT  per-lane select mask, all-ones or zero.
REQ-014 m_last  output  1  asserted with the final beat of a frame.
REQ-015 sel_count  output  $clog2(IMAGE_DIM*IMAGE_DIM+1)  selected-pixel count of the last completed frame.
REQ-016 frame_done  output  1  one-cycle pulse when sel_count updates.

Function
REQ-017 Per lane, SHALL compute Nx=(2*mx*my+C1)*(2*sxy+C2), Dx=(mx^2+my^2+C1)*(sxx+syy+C2), and Nz, Dz likewise with z in place of x, then p1=Nx*Dz and p2=Nz*Dx, with no truncation (terms 2*PIX_W+2 bits, N/D 4*PIX_W+4 bits, p 8*PIX_W+8 bits).
REQ-018 The lane output SHALL be all-ones when (cfg_ge ? p2>=p1 : p2>p1), else zero.
REQ-019 The pipeline SHALL have six register stages: mean products, sums, +C1/+C2, N/D products, cross products, compare/output register; latency SHALL be exactly 6 cycles from s_valid&&s_ready to m_valid with m_ready held high.
REQ-020 advance = !m_valid || m_ready; all stages SHALL shift only on advance; s_ready SHALL equal advance.
REQ-021 A per-stage valid bit SHALL travel with the data; bubbles SHALL NOT produce output beats.
REQ-022 m_data, m_last and m_valid SHALL remain stable while m_valid && !m_ready.
REQ-023 A beat counter SHALL count accepted input beats modulo IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT; the beat at count max-1 SHALL carry a last tag down the pipeline to m_last, and the counter SHALL then wrap to 0.
REQ-024 frame_clr SHALL zero the beat counter and statistics and invalidate all in-flight beats; if frame_clr coincides with an accepted beat, that beat SHALL be discarded.

Reset
REQ-025 On aresetn low: all stage valid bits, m_valid, m_last, frame_done, beat counter, sel_count and the running count SHALL be 0; m_data SHALL be 0.
REQ-026 Datapath registers other than m_data need no reset.
REQ-027 Reset mid-frame SHALL discard in-flight beats; the first beat accepted after release SHALL be frame beat 0.

Configuration
REQ-028 With macro HSSIM_SEL_STATS_EN defined, a running count SHALL add the popcount of selected lanes of each output transfer; on the m_last transfer, sel_count SHALL load the final total, frame_done SHALL pulse in the following cycle, and the running count SHALL restart at 0.
REQ-029 Without HSSIM_SEL_STATS_EN, sel_count and frame_done SHALL be tied to 0 and no counting logic SHALL exist.

Structure
REQ-030 A shared package hssim_pkg SHALL hold default C1/C2, width helper constants, and the beats-per-frame function.
REQ-031 A sub-module hssim_lane SHALL implement stages 1-5 for one pixel and SHALL be instantiated PIXELS_PER_BEAT times; handshake, counters and the output stage SHALL stay in the top module.

Verification
REQ-032 All means 100, all variances/covariances 50, cfg_ge=0 -> lane 0x00 (p1==p2); the same with cfg_ge=1 -> lane 0xFF.
REQ-033 mx=0, sxx=0, sxy=0, my=mz=100, syy=szz=szy=50 -> lane 0xFF exactly 6 cycles after acceptance.
REQ-034 Continuous input with m_ready low for 10 cycles -> s_ready low within the same cycle, no beat lost or duplicated, and order preserved.
REQ-035 PIXELS_PER_BEAT=16, IMAGE_DIM=16, stats enabled, 16 beats with 5 lanes each selected -> m_last on the 16th output, sel_count=80, one frame_done pulse.
REQ-036 aresetn pulsed low after 7 beats, then 16 beats sent -> no stale outputs, and m_last on the 16th post-reset output.

Source files
------------

// File: rtl/hssim_pkg.sv
// Shared constants, types and width helpers for the SSIM-select stream:
// default stabilising constants, per-stage widths and frame geometry.
package hssim_pkg;

  localparam int C1_DEFAULT = 6;
  localparam int C2_DEFAULT = 58;

  // Per-beat compare mode, captured with each accepted beat.
  typedef enum logic {
    CMP_STRICT = 1'b0,
    CMP_INCL   = 1'b1
  } cmp_mode_e;

  // Control tag that travels alongside the lane datapath.
  typedef struct packed {
    logic      vld;
    logic      last;
    cmp_mode_e mode;
  } tag_t;

  // Width of a C1/C2-stabilised term: mean/variance sum plus constant.
  function automatic int term_w(input int pix_w);
    return 2 * pix_w + 2;
  endfunction

  // Width of a numerator/denominator product of two terms.
  function automatic int nd_w(input int pix_w);
    return 4 * pix_w + 4;
  endfunction

  // Width of the cross products compared in the final stage.
  function automatic int prod_w(input int pix_w);
    return 8 * pix_w + 8;
  endfunction

  function automatic int beats_per_frame(input int image_dim, input int pixels_per_beat);
    return (image_dim * image_dim) / pixels_per_beat;
  endfunction

endpackage

// File: rtl/hssim_lane.sv
// One pixel lane of the SSIM-select datapath: five register stages ending
// in the cross products p1 = Nx*Dz and p2 = Nz*Dx, all widths lossless.
module hssim_lane
  import hssim_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int C1    = C1_DEFAULT,
  parameter int C2    = C2_DEFAULT
) (
  input  logic                       clk,
  input  logic                       i_adv,
  input  logic [PIX_W-1:0]           i_mu_x,
  input  logic [PIX_W-1:0]           i_mu_y,
  input  logic [PIX_W-1:0]           i_mu_z,
  input  logic [2*PIX_W-1:0]         i_sig_xx,
  input  logic [2*PIX_W-1:0]         i_sig_yy,
  input  logic [2*PIX_W-1:0]         i_sig_zz,
  input  logic [2*PIX_W-1:0]         i_sig_xy,
  input  logic [2*PIX_W-1:0]         i_sig_zy,
  output logic [prod_w(PIX_W)-1:0]   o_p1,
  output logic [prod_w(PIX_W)-1:0]   o_p2
);

  localparam int MW = 2 * PIX_W;
  localparam int TW = term_w(PIX_W);
  localparam int NW = nd_w(PIX_W);
  localparam int PW = prod_w(PIX_W);

  // Stage 1: mean products, variances forwarded
  logic [MW-1:0] r1_mxy, r1_mxx, r1_myy, r1_mzy, r1_mzz;
  logic [MW-1:0] r1_sxx, r1_syy, r1_szz, r1_sxy, r1_szy;
  // Stage 2: sums; Stage 3: sums plus stabilising constants
  logic [TW-1:0] r2_nm_x, r2_dm_x, r2_ns_x, r2_ds_x;
  logic [TW-1:0] r2_nm_z, r2_dm_z, r2_ns_z, r2_ds_z;
  logic [TW-1:0] r3_nm_x, r3_dm_x, r3_ns_x, r3_ds_x;
  logic [TW-1:0] r3_nm_z, r3_dm_z, r3_ns_z, r3_ds_z;
  // Stage 4: N/D products; Stage 5: cross products
  logic [NW-1:0] r4_nx, r4_dx, r4_nz, r4_dz;
  logic [PW-1:0] r5_p1, r5_p2;

  // NOTE: datapath registers carry no reset; validity is tracked by the
  // tag chain in the top, so stale contents here are never observed.
  always_ff @(posedge clk) begin
    if (i_adv) begin
      r1_mxy  <= MW'(i_mu_x) * MW'(i_mu_y);
      r1_mxx  <= MW'(i_mu_x) * MW'(i_mu_x);
      r1_myy  <= MW'(i_mu_y) * MW'(i_mu_y);
      r1_mzy  <= MW'(i_mu_z) * MW'(i_mu_y);
      r1_mzz  <= MW'(i_mu_z) * MW'(i_mu_z);
      r1_sxx  <= i_sig_xx;
      r1_syy  <= i_sig_yy;
      r1_szz  <= i_sig_zz;
      r1_sxy  <= i_sig_xy;
      r1_szy  <= i_sig_zy;

      r2_nm_x <= TW'({r1_mxy, 1'b0});
      r2_dm_x <= TW'(r1_mxx) + TW'(r1_myy);
      r2_ns_x <= TW'({r1_sxy, 1'b0});
      r2_ds_x <= TW'(r1_sxx) + TW'(r1_syy);
      r2_nm_z <= TW'({r1_mzy, 1'b0});
      r2_dm_z <= TW'(r1_mzz) + TW'(r1_myy);
      r2_ns_z <= TW'({r1_szy, 1'b0});
      r2_ds_z <= TW'(r1_szz) + TW'(r1_syy);

      r3_nm_x <= r2_nm_x + TW'(C1);
      r3_dm_x <= r2_dm_x + TW'(C1);
      r3_ns_x <= r2_ns_x + TW'(C2);
      r3_ds_x <= r2_ds_x + TW'(C2);
      r3_nm_z <= r2_nm_z + TW'(C1);
      r3_dm_z <= r2_dm_z + TW'(C1);
      r3_ns_z <= r2_ns_z + TW'(C2);
      r3_ds_z <= r2_ds_z + TW'(C2);

      r4_nx   <= NW'(r3_nm_x) * NW'(r3_ns_x);
      r4_dx   <= NW'(r3_dm_x) * NW'(r3_ds_x);
      r4_nz   <= NW'(r3_nm_z) * NW'(r3_ns_z);
      r4_dz   <= NW'(r3_dm_z) * NW'(r3_ds_z);

      r5_p1   <= PW'(r4_nx) * PW'(r4_dz);
      r5_p2   <= PW'(r4_nz) * PW'(r4_dx);
    end
  end

  assign o_p1 = r5_p1;
  assign o_p2 = r5_p2;

endmodule

// File: rtl/hssim_sel_stream.sv
// Streaming SSIM selector: per lane, marks pixels where the new map beats the
// old one. Frame statistics (sel_count/frame_done) exist only with HSSIM_SEL_STATS_EN.
module hssim_sel_stream
  import hssim_pkg::*;
#(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int PIX_W           = 8,
  parameter int IMAGE_DIM       = 512,
  parameter int C1              = C1_DEFAULT,
  parameter int C2              = C2_DEFAULT
) (
  input  logic                                   clk,
  input  logic                                   aresetn,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [PIX_W*PIXELS_PER_BEAT-1:0]       mu_x,
  input  logic [PIX_W*PIXELS_PER_BEAT-1:0]       mu_y,
  input  logic [PIX_W*PIXELS_PER_BEAT-1:0]       mu_z,
  input  logic [2*PIX_W*PIXELS_PER_BEAT-1:0]     sig_xx,
  input  logic [2*PIX_W*PIXELS_PER_BEAT-1:0]     sig_yy,
  input  logic [2*PIX_W*PIXELS_PER_BEAT-1:0]     sig_zz,
  input  logic [2*PIX_W*PIXELS_PER_BEAT-1:0]     sig_xy,
  input  logic [2*PIX_W*PIXELS_PER_BEAT-1:0]     sig_zy,
  input  logic                                   cfg_ge,
  input  logic                                   frame_clr,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [PIX_W*PIXELS_PER_BEAT-1:0]       m_data,
  output logic                                   m_last,
  output logic [$clog2(IMAGE_DIM*IMAGE_DIM+1)-1:0] sel_count,
  output logic                                   frame_done
);

  localparam int LANES   = PIXELS_PER_BEAT;
  localparam int BEATS   = beats_per_frame(IMAGE_DIM, PIXELS_PER_BEAT);
  localparam int BCNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW      = prod_w(PIX_W);
  localparam int SW      = 2 * PIX_W;

  logic              w_adv;
  tag_t              w_tag_in;
  tag_t              r_tag [1:5];
  logic [BCNT_W-1:0] r_bcnt;
  logic [PW-1:0]     w_p1 [LANES];
  logic [PW-1:0]     w_p2 [LANES];
  logic [LANES-1:0]  w_sel;
  logic [PIX_W*LANES-1:0] w_mask;

  // The whole pipeline moves as one; any stall freezes every stage.
  assign w_adv   = !m_valid || m_ready;
  assign s_ready = w_adv;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    hssim_lane #(
      .PIX_W (PIX_W),
      .C1    (C1),
      .C2    (C2)
    ) u_lane (
      .clk      (clk),
      .i_adv    (w_adv),
      .i_mu_x   (mu_x[l*PIX_W +: PIX_W]),
      .i_mu_y   (mu_y[l*PIX_W +: PIX_W]),
      .i_mu_z   (mu_z[l*PIX_W +: PIX_W]),
      .i_sig_xx (sig_xx[l*SW +: SW]),
      .i_sig_yy (sig_yy[l*SW +: SW]),
      .i_sig_zz (sig_zz[l*SW +: SW]),
      .i_sig_xy (sig_xy[l*SW +: SW]),
      .i_sig_zy (sig_zy[l*SW +: SW]),
      .o_p1     (w_p1[l]),
      .o_p2     (w_p2[l])
    );
  end

  // NOTE: every combinational output gets a default first so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_tag_in      = '0;
    w_tag_in.vld  = s_valid;
    w_tag_in.last = s_valid && (r_bcnt == BCNT_W'(BEATS - 1));
    w_tag_in.mode = cmp_mode_e'(cfg_ge);
  end

  always_comb begin
    w_sel  = '0;
    w_mask = '0;
    for (int l = 0; l < LANES; l++) begin
      w_sel[l] = (r_tag[5].mode == CMP_INCL) ? (w_p2[l] >= w_p1[l])
                                             : (w_p2[l] >  w_p1[l]);
      w_mask[l*PIX_W +: PIX_W] = {PIX_W{w_sel[l]}};
    end
  end

  // Tag chain, frame beat counter and the output register (stage 6).
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 1; i <= 5; i++) r_tag[i] <= '0;
      r_bcnt  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else if (frame_clr) begin
      for (int i = 1; i <= 5; i++) r_tag[i] <= '0;
      r_bcnt  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (w_adv) begin
      r_tag[1] <= w_tag_in;
      for (int i = 2; i <= 5; i++) r_tag[i] <= r_tag[i-1];
      m_valid  <= r_tag[5].vld;
      m_last   <= r_tag[5].last;
      m_data   <= w_mask;
      if (s_valid) begin
        r_bcnt <= (r_bcnt == BCNT_W'(BEATS - 1)) ? '0 : r_bcnt + BCNT_W'(1);
      end
    end
  end

`ifdef HSSIM_SEL_STATS_EN
  localparam int CNT_W = $clog2(IMAGE_DIM*IMAGE_DIM+1);
  localparam int PC_W  = $clog2(LANES+1);

  logic [CNT_W-1:0] r_run;
  logic [PC_W-1:0]  w_pop;
  logic             w_xfer;

  assign w_xfer = m_valid && m_ready;

  // Lane masks are all-ones or zero, so bit 0 of each lane is its select.
  always_comb begin
    w_pop = '0;
    for (int l = 0; l < LANES; l++) begin
      w_pop = w_pop + PC_W'(m_data[l*PIX_W]);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_run      <= '0;
      sel_count  <= '0;
      frame_done <= 1'b0;
    end else if (frame_clr) begin
      r_run      <= '0;
      sel_count  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_xfer && m_last;
      if (w_xfer) begin
        if (m_last) begin
          sel_count <= r_run + CNT_W'(w_pop);
          r_run     <= '0;
        end else begin
          r_run     <= r_run + CNT_W'(w_pop);
        end
      end
    end
  end
`else
  assign sel_count  = '0;
  assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_hssim_sel_stream.sv
// Self-checking bench for hssim_sel_stream (16 lanes, 16x16 frame): table and
// random beats feed a scoreboard compared at every output transfer.
module tb_hssim_sel_stream;

  localparam int PPB   = 16;
  localparam int PW    = 8;
  localparam int DIM   = 16;
  localparam int BEATS = DIM * DIM / PPB;
  localparam int DW    = PPB * PW;
  localparam int SW    = 2 * DW;
  localparam int CW    = $clog2(DIM*DIM+1);
  localparam int TC1   = 6;
  localparam int TC2   = 58;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] mu_x = '0, mu_y = '0, mu_z = '0;
  logic [SW-1:0] sig_xx = '0, sig_yy = '0, sig_zz = '0, sig_xy = '0, sig_zy = '0;
  logic          cfg_ge = 1'b0;
  logic          frame_clr = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [CW-1:0] sel_count;
  logic          frame_done;

  always #5 clk = ~clk;

  hssim_sel_stream #(
    .PIXELS_PER_BEAT (PPB),
    .PIX_W           (PW),
    .IMAGE_DIM       (DIM)
  ) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .mu_x       (mu_x),
    .mu_y       (mu_y),
    .mu_z       (mu_z),
    .sig_xx     (sig_xx),
    .sig_yy     (sig_yy),
    .sig_zz     (sig_zz),
    .sig_xy     (sig_xy),
    .sig_zy     (sig_zy),
    .cfg_ge     (cfg_ge),
    .frame_clr  (frame_clr),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .sel_count  (sel_count),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [7:0]  mx, my, mz;
    logic [15:0] sxx, syy, szz, sxy, szy;
    logic        exp_strict, exp_incl;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            acc_cyc;
  } sb_t;

  localparam int V_EQ = 0, V_Z = 1, V_X = 2, V_ZERO = 3, V_BIGX = 4, V_BIGZ = 5;

  vec_t          tbl [6];
  sb_t           sb [$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            bidx     = 0;
  int            n_last   = 0;
  int            n_fd     = 0;
  int            run_cnt  = 0;
  bit            lat_chk  = 1'b1;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] cur_exp  = '0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  logic [CW-1:0] exp_sel  = '0;
  logic          exp_fd   = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %s", name, what);
  endtask

  function automatic logic model_sel(input vec_t v, input logic ge);
    logic [127:0] mx, my, mz, sxx, syy, szz, sxy, szy, nx, dx, nz, dz, p1, p2;
    mx  = 128'(v.mx);  my  = 128'(v.my);  mz  = 128'(v.mz);
    sxx = 128'(v.sxx); syy = 128'(v.syy); szz = 128'(v.szz);
    sxy = 128'(v.sxy); szy = 128'(v.szy);
    nx = (2 * mx * my + TC1) * (2 * sxy + TC2);
    dx = (mx * mx + my * my + TC1) * (sxx + syy + TC2);
    nz = (2 * mz * my + TC1) * (2 * szy + TC2);
    dz = (mz * mz + my * my + TC1) * (szz + syy + TC2);
    p1 = nx * dz;
    p2 = nz * dx;
    return ge ? (p2 >= p1) : (p2 > p1);
  endfunction

  task automatic set_lane(input int l, input vec_t v, input logic sel);
    mu_x[l*PW +: PW]       = v.mx;
    mu_y[l*PW +: PW]       = v.my;
    mu_z[l*PW +: PW]       = v.mz;
    sig_xx[l*2*PW +: 2*PW] = v.sxx;
    sig_yy[l*2*PW +: 2*PW] = v.syy;
    sig_zz[l*2*PW +: 2*PW] = v.szz;
    sig_xy[l*2*PW +: 2*PW] = v.sxy;
    sig_zy[l*2*PW +: 2*PW] = v.szy;
    cur_exp[l*PW +: PW]    = {PW{sel}};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds s_valid until the beat is accepted (bounded).
  task automatic send();
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("s_ready_wait", "timeout, want acceptance");
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_table(input int base, input logic ge);
    vec_t v;
    cfg_ge = ge;
    for (int l = 0; l < PPB; l++) begin
      v = tbl[(base + l) % 6];
      set_lane(l, v, ge ? v.exp_incl : v.exp_strict);
    end
    send();
  endtask

  task automatic send_random();
    vec_t v;
    cfg_ge = 1'($urandom_range(0, 1));
    for (int l = 0; l < PPB; l++) begin
      v.mx  = 8'($urandom);  v.my  = 8'($urandom);  v.mz  = 8'($urandom);
      v.sxx = 16'($urandom); v.syy = 16'($urandom); v.szz = 16'($urandom);
      v.sxy = 16'($urandom); v.szy = 16'($urandom);
      v.exp_strict = 1'b0;   v.exp_incl = 1'b0;
      set_lane(l, v, model_sel(v, cfg_ge));
    end
    send();
  endtask

  // Five lanes selected per beat, at a rotating position.
  task automatic send_five(input int b);
    vec_t v;
    cfg_ge = 1'($urandom_range(0, 1));
    for (int l = 0; l < PPB; l++) begin
      v = (((l + b) % PPB) < 5) ? tbl[V_Z] : tbl[V_X];
      set_lane(l, v, cfg_ge ? v.exp_incl : v.exp_strict);
    end
    send();
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      if (sb.size() == 0) break;
      tick();
    end
    if (sb.size() != 0) fail_now("drain", "outputs missing, want empty scoreboard");
    repeat (3) tick();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and cycle-level protocol monitor.
  always @(negedge clk) begin : mon
    sb_t e;
    int  pc;
    if (!aresetn) begin
      check("rst_m_valid", DW'(m_valid), '0);
      check("rst_m_last", DW'(m_last), '0);
      check("rst_m_data", m_data, '0);
      check("rst_sel_count", DW'(sel_count), '0);
      check("rst_frame_done", DW'(frame_done), '0);
      sb.delete();
      bidx = 0; run_cnt = 0; exp_sel = '0; exp_fd = 1'b0; prev_stall = 1'b0;
    end else begin
      check("s_ready", DW'(s_ready), DW'(!m_valid || m_ready));
      check("frame_done", DW'(frame_done), DW'(exp_fd));
      check("sel_count", DW'(sel_count), DW'(exp_sel));
      if (frame_done) n_fd++;
      if (prev_stall) begin
        check("stall_m_valid", DW'(m_valid), DW'(1));
        check("stall_m_data", m_data, prev_data);
        check("stall_m_last", DW'(m_last), DW'(prev_last));
      end
      exp_fd = 1'b0;
      if (frame_clr) begin
        sb.delete();
        bidx = 0; run_cnt = 0; exp_sel = '0;
      end else begin
        if (m_valid && m_ready) begin
          if (m_last) n_last++;
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got m_data %0h, want no output", m_data);
          end else begin
            e = sb.pop_front();
            check("m_data", m_data, e.data);
            check("m_last", DW'(m_last), DW'(e.last));
            if (lat_chk) check("latency", DW'(cyc - e.acc_cyc), DW'(6));
`ifdef HSSIM_SEL_STATS_EN
            pc = 0;
            for (int l = 0; l < PPB; l++) pc += int'(e.data[l*PW]);
            if (e.last) begin
              exp_sel = CW'(run_cnt + pc);
              run_cnt = 0;
              exp_fd  = 1'b1;
            end else begin
              run_cnt += pc;
            end
`endif
          end
        end
        if (s_valid && s_ready) begin
          e.data    = cur_exp;
          e.last    = (bidx == BEATS - 1);
          e.acc_cyc = cyc;
          sb.push_back(e);
          bidx = (bidx + 1) % BEATS;
        end
      end
      prev_stall = m_valid && !m_ready && !frame_clr;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, want finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : stim
    int fd0, l0;
    tbl[V_EQ]   = '{8'd100, 8'd100, 8'd100, 16'd50, 16'd50, 16'd50, 16'd50, 16'd50, 1'b0, 1'b1};
    tbl[V_Z]    = '{8'd0,   8'd100, 8'd100, 16'd0,  16'd50, 16'd50, 16'd0,  16'd50, 1'b1, 1'b1};
    tbl[V_X]    = '{8'd100, 8'd100, 8'd0,   16'd50, 16'd50, 16'd0,  16'd50, 16'd0,  1'b0, 1'b0};
    tbl[V_ZERO] = '{8'd0,   8'd0,   8'd0,   16'd0,  16'd0,  16'd0,  16'd0,  16'd0,  1'b0, 1'b1};
    tbl[V_BIGX] = '{8'd255, 8'd255, 8'd0,   16'd65535, 16'd65535, 16'd65535, 16'd65535, 16'd0, 1'b0, 1'b0};
    tbl[V_BIGZ] = '{8'd0,   8'd255, 8'd255, 16'd65535, 16'd65535, 16'd65535, 16'd0, 16'd65535, 1'b1, 1'b1};

    aresetn = 1'b0;
    repeat (3) tick();
    aresetn = 1'b1;
    tick();

    // Table vectors, rotated across lanes, both compare modes.
    for (int v = 0; v < 6; v++) begin
      for (int g = 0; g < 2; g++) send_table(v, 1'(g));
    end
    repeat (8) send_random();
    drain();

    // frame_clr flushes in-flight beats and discards a coincident beat.
    repeat (3) send_random();
    frame_clr = 1'b1;
    s_valid   = 1'b1;
    tick();
    frame_clr = 1'b0;
    s_valid   = 1'b0;
    repeat (10) tick();

    // One full frame, five lanes selected per beat.
    fd0 = n_fd;
    l0  = n_last;
    for (int b = 0; b < BEATS; b++) send_five(b);
    drain();
    check("frame_last_count", DW'(n_last - l0), DW'(1));
`ifdef HSSIM_SEL_STATS_EN
    check("frame_sel_count", DW'(sel_count), DW'(80));
    check("frame_done_pulses", DW'(n_fd - fd0), DW'(1));
`else
    check("frame_sel_count", DW'(sel_count), DW'(0));
    check("frame_done_pulses", DW'(n_fd - fd0), DW'(0));
`endif

    // Back-pressure: fixed 10-cycle stall, then random m_ready.
    lat_chk = 1'b0;
    fork
      repeat (30) send_random();
      begin
        repeat (8) tick();
        m_ready = 1'b0;
        repeat (10) tick();
        m_ready = 1'b1;
      end
    join
    fork
      repeat (20) send_random();
      begin
        repeat (40) begin
          m_ready = 1'($urandom_range(0, 1));
          tick();
        end
        m_ready = 1'b1;
      end
    join
    m_ready = 1'b1;
    drain();
    lat_chk = 1'b1;

    // Reset in mid-frame, then a full frame from beat 0.
    repeat (7) send_random();
    aresetn = 1'b0;
    repeat (2) tick();
    aresetn = 1'b1;
    tick();
    l0 = n_last;
    repeat (BEATS) send_random();
    drain();
    check("rst_frame_last_count", DW'(n_last - l0), DW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
